// File: rtl/cond_flags_unit_if.sv
// Bus between the multicycle control FSM/decoder and cond_flags_unit.
// Optional saturation-flag signals appear when COND_Q_FLAG_EN is defined.
interface cond_flags_unit_if;
  logic       IRWrite;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       WE4w;
  logic       MemW;
  logic       NoWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       RegWrite2;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondExOut;
`ifdef COND_Q_FLAG_EN
  logic       QSet;
  logic       QClr;
  logic       FlagQ;

  modport master (
    output IRWrite, Cond, ALUFlags, FlagW, PCS, NextPC, RegW, WE4w, MemW, NoWrite,
    output QSet, QClr,
    input  PCWrite, RegWrite, RegWrite2, MemWrite, Flags, CondExOut, FlagQ
  );
  modport slave (
    input  IRWrite, Cond, ALUFlags, FlagW, PCS, NextPC, RegW, WE4w, MemW, NoWrite,
    input  QSet, QClr,
    output PCWrite, RegWrite, RegWrite2, MemWrite, Flags, CondExOut, FlagQ
  );
`else
  modport master (
    output IRWrite, Cond, ALUFlags, FlagW, PCS, NextPC, RegW, WE4w, MemW, NoWrite,
    input  PCWrite, RegWrite, RegWrite2, MemWrite, Flags, CondExOut
  );
  modport slave (
    input  IRWrite, Cond, ALUFlags, FlagW, PCS, NextPC, RegW, WE4w, MemW, NoWrite,
    output PCWrite, RegWrite, RegWrite2, MemWrite, Flags, CondExOut
  );
`endif
endinterface

// File: rtl/cond_flags_unit.sv
// NZCV flag register and per-instruction condition evaluation that gates the
// FSM write strobes. Define COND_Q_FLAG_EN to add the sticky Q saturation flag.
module cond_flags_unit (
  input  logic               clk,
  input  logic               reset,
  cond_flags_unit_if.slave   bus
);

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  logic [3:0] r_flags;
  logic       r_cond_ex;
  logic       r_irw_d;

  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic       w_cond_ex;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Evaluated against the architectural flags, never the in-flight ALU flags.
  always_comb begin
    // NOTE: default first so every path assigns w_cond_ex and no latch is inferred.
    w_cond_ex = 1'b0;
    unique case (cond_e'(bus.Cond))
      CC_EQ: w_cond_ex = w_z;
      CC_NE: w_cond_ex = ~w_z;
      CC_CS: w_cond_ex = w_c;
      CC_CC: w_cond_ex = ~w_c;
      CC_MI: w_cond_ex = w_n;
      CC_PL: w_cond_ex = ~w_n;
      CC_VS: w_cond_ex = w_v;
      CC_VC: w_cond_ex = ~w_v;
      CC_HI: w_cond_ex = w_c & ~w_z;
      CC_LS: w_cond_ex = ~w_c | w_z;
      CC_GE: w_cond_ex = (w_n == w_v);
      CC_LT: w_cond_ex = (w_n != w_v);
      CC_GT: w_cond_ex = ~w_z & (w_n == w_v);
      CC_LE: w_cond_ex = w_z | (w_n != w_v);
      CC_AL: w_cond_ex = 1'b1;
      CC_NV: w_cond_ex = 1'b0;
    endcase
  end

  // Flag halves update from the pre-edge CondExReg; CondExReg captures from
  // pre-edge flags, so a decode edge and a flag write can coincide safely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags   <= 4'b0000;
      r_cond_ex <= 1'b0;
      r_irw_d   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      r_irw_d <= bus.IRWrite;
      if (r_irw_d)
        r_cond_ex <= w_cond_ex;
      if (bus.FlagW[1] & r_cond_ex)
        r_flags[3:2] <= bus.ALUFlags[3:2];
      if (bus.FlagW[0] & r_cond_ex)
        r_flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

`ifdef COND_Q_FLAG_EN
  logic r_flag_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_flag_q <= 1'b0;
    else if (bus.QClr)
      r_flag_q <= 1'b0;
    else if (bus.QSet & r_cond_ex)
      r_flag_q <= 1'b1;
  end

  assign bus.FlagQ = r_flag_q;
`endif

  // Zero-latency gating; reset clears r_cond_ex so only the fetch PC update survives.
  assign bus.PCWrite   = bus.NextPC | (bus.PCS & r_cond_ex);
  assign bus.RegWrite  = bus.RegW & r_cond_ex & ~bus.NoWrite;
  assign bus.RegWrite2 = bus.WE4w & r_cond_ex;
  assign bus.MemWrite  = bus.MemW & r_cond_ex;
  assign bus.Flags     = r_flags;
  assign bus.CondExOut = r_cond_ex;

endmodule
